// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath widths, opcodes and the ID/EX bundle.
package mips_pkg;

    localparam int DW      = 32;
    localparam int ALUOP_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Resolved bundle: b and dest hold the already-selected values.
    typedef struct packed {
        logic [DW-1:0]      pc4;
        logic [DW-1:0]      a;
        logic [DW-1:0]      b;
        logic [DW-1:0]      rt_data;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         dest;
        logic [4:0]         shamt;
        logic [ALUOP_W-1:0] alu_op;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               branch;
    } id_ex_t;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/skid_reg.sv
// Generic 2-entry valid/ready buffer: main register drives the outputs, skid
// register absorbs one extra beat so in_ready depends only on local state.
module skid_reg #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic m_valid_q, m_valid_d;
    logic s_valid_q, s_valid_d;
    T     m_data_q, m_data_d;
    T     s_data_q, s_data_d;

    logic accept;
    logic xfer;

    assign in_ready  = !s_valid_q;
    assign out_valid = m_valid_q;
    assign out_data  = m_data_q;

    assign accept = in_valid && !s_valid_q;
    assign xfer   = m_valid_q && out_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        if (flush) begin
            // Data is left stale; only the valid bits matter downstream.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || xfer) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                s_valid_d = accept;
                if (accept) s_data_d = in_data;
            end else begin
                m_valid_d = accept;
                if (accept) m_data_d = in_data;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: resolves the B operand and destination register, then
// holds the bundle in a skid buffer so the decode-side ready is registered.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_pc4,
    input  logic [DW-1:0]      in_rs_data,
    input  logic [DW-1:0]      in_rt_data,
    input  logic [DW-1:0]      in_imm,
    input  logic [4:0]         in_rs,
    input  logic [4:0]         in_rt,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_shamt,
    input  logic [ALUOP_W-1:0] in_alu_op,
    input  logic               in_alu_src,
    input  logic               in_reg_dst,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic               in_mem_to_reg,
    input  logic               in_branch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_pc4,
    output logic [DW-1:0]      out_a,
    output logic [DW-1:0]      out_b,
    output logic [DW-1:0]      out_rt_data,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_dest,
    output logic [4:0]         out_shamt,
    output logic [ALUOP_W-1:0] out_alu_op,
    output logic               out_reg_write,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_mem_to_reg,
    output logic               out_branch
);

    id_ex_t in_bundle;
    id_ex_t out_bundle;

    always_comb begin
        in_bundle            = '0;
        in_bundle.pc4        = in_pc4;
        in_bundle.a          = in_rs_data;
        in_bundle.b          = in_alu_src ? in_imm : in_rt_data;
        in_bundle.rt_data    = in_rt_data;
        in_bundle.rs         = in_rs;
        in_bundle.rt         = in_rt;
        in_bundle.dest       = in_reg_dst ? in_rd : in_rt;
        in_bundle.shamt      = in_shamt;
        in_bundle.alu_op     = in_alu_op;
        in_bundle.reg_write  = in_reg_write;
        in_bundle.mem_read   = in_mem_read;
        in_bundle.mem_write  = in_mem_write;
        in_bundle.mem_to_reg = in_mem_to_reg;
        in_bundle.branch     = in_branch;
    end

    skid_reg #(.T(id_ex_t)) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_bundle),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_bundle)
    );

    assign out_pc4        = out_bundle.pc4;
    assign out_a          = out_bundle.a;
    assign out_b          = out_bundle.b;
    assign out_rt_data    = out_bundle.rt_data;
    assign out_rs         = out_bundle.rs;
    assign out_rt         = out_bundle.rt;
    assign out_dest       = out_bundle.dest;
    assign out_shamt      = out_bundle.shamt;
    assign out_alu_op     = out_bundle.alu_op;
    assign out_reg_write  = out_bundle.reg_write;
    assign out_mem_read   = out_bundle.mem_read;
    assign out_mem_write  = out_bundle.mem_write;
    assign out_mem_to_reg = out_bundle.mem_to_reg;
    assign out_branch     = out_bundle.branch;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and random checks of the ID/EX stage against a 2-deep queue model.
module tb_id_ex_stage;
    import mips_pkg::*;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [DW-1:0]      in_pc4, in_rs_data, in_rt_data, in_imm;
    logic [4:0]         in_rs, in_rt, in_rd, in_shamt;
    logic [ALUOP_W-1:0] in_alu_op;
    logic               in_alu_src, in_reg_dst, in_reg_write, in_mem_read;
    logic               in_mem_write, in_mem_to_reg, in_branch;
    logic [DW-1:0]      out_pc4, out_a, out_b, out_rt_data;
    logic [4:0]         out_rs, out_rt, out_dest, out_shamt;
    logic [ALUOP_W-1:0] out_alu_op;
    logic               out_reg_write, out_mem_read, out_mem_write;
    logic               out_mem_to_reg, out_branch;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
        .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_alu_op(in_alu_op), .in_alu_src(in_alu_src),
        .in_reg_dst(in_reg_dst), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_mem_to_reg(in_mem_to_reg), .in_branch(in_branch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc4(out_pc4), .out_a(out_a), .out_b(out_b),
        .out_rt_data(out_rt_data), .out_rs(out_rs), .out_rt(out_rt),
        .out_dest(out_dest), .out_shamt(out_shamt), .out_alu_op(out_alu_op),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
        .out_branch(out_branch)
    );

    function automatic id_ex_t got();
        id_ex_t g;
        g = '{out_pc4, out_a, out_b, out_rt_data, out_rs, out_rt, out_dest,
              out_shamt, out_alu_op, out_reg_write, out_mem_read,
              out_mem_write, out_mem_to_reg, out_branch};
        return g;
    endfunction

    // Every field of instruction `id` is derived from id; bit0 picks alu_src, bit1 reg_dst.
    function automatic id_ex_t exp_of(input logic [31:0] id);
        id_ex_t e;
        logic [31:0] imm, rtd;
        logic [4:0]  rt, rd;
        imm  = 32'hFFFF_0000 | id;
        rtd  = 32'h2000_0000 + id;
        rt   = 5'(id + 32'd1);
        rd   = 5'(id + 32'd2);
        e.pc4 = 32'h0040_0000 + (id << 2);
        e.a   = 32'h1000_0000 + id;
        e.b   = id[0] ? imm : rtd;
        e.rt_data = rtd;
        e.rs  = id[4:0];
        e.rt  = rt;
        e.dest = id[1] ? rd : rt;
        e.shamt = 5'(id + 32'd3);
        e.alu_op = id[3:0];
        e.reg_write = id[4]; e.mem_read = id[5]; e.mem_write = id[6];
        e.mem_to_reg = id[7]; e.branch = id[8];
        return e;
    endfunction

    task automatic drive(input logic [31:0] id, input logic vld);
        in_valid   = vld;
        in_pc4     = 32'h0040_0000 + (id << 2);
        in_rs_data = 32'h1000_0000 + id;
        in_rt_data = 32'h2000_0000 + id;
        in_imm     = 32'hFFFF_0000 | id;
        in_rs      = id[4:0];
        in_rt      = 5'(id + 32'd1);
        in_rd      = 5'(id + 32'd2);
        in_shamt   = 5'(id + 32'd3);
        in_alu_op  = id[3:0];
        in_alu_src = id[0];
        in_reg_dst = id[1];
        {in_branch, in_mem_to_reg, in_mem_write, in_mem_read, in_reg_write} = id[8:4];
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(32'd5, 1'b1);
        step(); step();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (got() !== id_ex_t'(0)) begin errors++; $display("FAIL reset_outputs got %h want 0", got()); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        drive(32'd0, 1'b1);
        in_imm = 32'hFFFF_FFFC; in_rt_data = 32'h0000_0055;
        in_alu_src = 1'b1; in_rt = 5'd9; in_rd = 5'd17; in_reg_dst = 1'b0;
        step();
        in_rt_data = 32'h0000_0007; in_imm = 32'h0000_1234;
        in_rd = 5'd12; in_rt = 5'd3; in_alu_src = 1'b0; in_reg_dst = 1'b1;
        checks++;
        if (out_valid !== 1'b1 || out_b !== 32'hFFFF_FFFC || out_dest !== 5'd9) begin
            errors++; $display("FAIL stream_addi got v=%b b=%h d=%0d want v=1 b=fffffffc d=9", out_valid, out_b, out_dest);
        end
        checks++;
        if (out_rt_data !== 32'h0000_0055) begin errors++; $display("FAIL stream_addi_rtdata got %h want 55", out_rt_data); end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_b !== 32'h7 || out_dest !== 5'd12) begin
            errors++; $display("FAIL stream_rtype got v=%b b=%h d=%0d want v=1 b=7 d=12", out_valid, out_b, out_dest);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(32'd1, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_after1 got %b want 1", in_ready); end
        drive(32'd2, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready_after2 got %b want 0", in_ready); end
        drive(32'd3, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b0 || got() !== exp_of(32'd1)) begin
            errors++; $display("FAIL skid_hold got rdy=%b %h want rdy=0 %h", in_ready, got(), exp_of(32'd1));
        end
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || got() !== exp_of(32'd2) || in_ready !== 1'b1) begin
            errors++; $display("FAIL skid_second got v=%b rdy=%b %h want %h", out_valid, in_ready, got(), exp_of(32'd2));
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || got() !== exp_of(32'd3)) begin
            errors++; $display("FAIL skid_third got v=%b %h want %h", out_valid, got(), exp_of(32'd3));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'd10, 1'b1); step();
        drive(32'd11, 1'b1); step();
        drive(32'd12, 1'b1); flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak cycle %0d got v=%b want 0", i, out_valid); end
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        drive(32'd20, 1'b1); step();
        drive(32'd21, 1'b1); step();
        drive(32'd22, 1'b1); out_ready = 1'b1; flush = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got() !== id_ex_t'(0)) begin
            errors++; $display("FAIL midrst_state got v=%b rdy=%b %h want v=0 rdy=1 0", out_valid, in_ready, got());
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_leak cycle %0d got v=%b want 0", i, out_valid); end
        end
    endtask

    task automatic test_random();
        id_ex_t      q[$];
        logic [31:0] next_id = 32'd100;
        int          bad = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            drive(next_id, ($urandom_range(0, 9) < 7));
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 39) == 0);
            @(negedge clk);
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_flags cyc %0d got v=%b rdy=%b want depth %0d", cyc, out_valid, in_ready, q.size());
            end else if (out_valid) begin
                checks++;
                if (got() !== q[0]) begin
                    errors++; bad++;
                    if (bad < 10) $display("FAIL rand_data cyc %0d got %h want %h", cyc, got(), q[0]);
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && q.size() < 2 + ((out_ready && q.size() != 0) ? 1 : 0) && in_ready) begin
                    q.push_back(exp_of(next_id));
                    next_id++;
                end
            end
            step();
        end
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the MIPS core. It sits directly downstream of the sign/zero-extension unit and the register file, and upstream of the ALU. It captures one decoded instruction per handshake: register operands, the 32-bit extended immediate, register specifiers and control bits. It holds them behind a 2-entry skid buffer, so the decode-side ready is fully registered. It also resolves the ALU B operand and the destination register before presenting the bundle to EX.

## Interface
- `DW`, 32, datapath width (operands, immediate, PC+4).
- `ALUOP_W`, 4, ALU operation code width.
- `clk` in 1: the single clock; everything is sampled on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: kill all held instructions (branch/jump redirect from EX).
- `in_valid` in 1: decode presents an instruction.
- `in_ready` out 1: stage can accept; registered.
- `in_pc4` in DW: PC+4 of the instruction.
- `in_rs_data`, `in_rt_data` in DW: register-file read data.
- `in_imm` in DW: sign/zero-extended immediate.
- `in_rs`, `in_rt`, `in_rd` in 5: register specifiers.
- `in_shamt` in 5: shift amount.
- `in_alu_op` in ALUOP_W: ALU operation.
- `in_alu_src` in 1: 1 = B operand is `in_imm`, 0 = `in_rt_data`.
- `in_reg_dst` in 1: 1 = destination is rd, 0 = rt.
- `in_reg_write`, `in_mem_read`, `in_mem_write`, `in_mem_to_reg`, `in_branch` in 1 each: control bits.
- `out_valid` out 1: entry presented to EX.
- `out_ready` in 1: EX accepts.
- `out_pc4`, `out_a`, `out_b`, `out_rt_data` out DW: PC+4, A operand (= rs_data), resolved B operand, raw rt data (store data).
- `out_rs`, `out_rt`, `out_dest` out 5: specifiers for forwarding; resolved destination.
- `out_shamt` out 5, `out_alu_op` out ALUOP_W, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_mem_to_reg`, `out_branch` out 1 each: registered copies.

## Operation
- Bundle resolution at capture: `b = alu_src ? imm : rt_data`; `dest = reg_dst ? rd : rt`. Resolved values are stored, not raw selects.
- Storage is a main register (M) and a skid register (S), each with a valid bit.
- Outputs are always driven from M; `out_valid = M.valid`.
- `in_ready = !S.valid`.
- Input accept occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Per cycle, with no flush:
  - M empty, or M transfers this cycle: if S is valid, S moves to M and an accepted input goes to S. Otherwise an accepted input goes to M.
  - M stalled: an accepted input goes to S.
- `in_ready` is registered, so an accept can arrive in the same cycle S fills. This is safe because S is only written when it was empty.
- Flush: both valid bits clear at the edge; any same-cycle accept is discarded; `in_ready` = 1 next cycle. Flush has priority over everything except `rst`.
- Reset: M.valid = S.valid = 0, and all data and control registers = 0. Hence `out_valid` = 0, every `out_*` = 0, and `in_ready` = 1 in the first cycle after reset.
- Invalid entries keep stale data. Downstream must qualify on `out_valid`; control bits are not separately zeroed.
- Ordering is strict FIFO; an instruction is never duplicated or dropped except by flush or reset.

## Timing
- Latency: an input accepted at edge N is visible on the outputs after edge N. This applies when M is empty or transferring; otherwise the input waits behind M.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- Ready path: one `out_ready` low cycle fills S; `in_ready` drops the following cycle. There is no combinational path from `out_ready` to `in_ready`.
- Reset mid-operation: takes effect at the next edge regardless of `flush`, `in_valid` or `out_ready`.

## Structure
- Shared package `mips_pkg` holds:
  - `DW` and `ALUOP_W` constants;
  - `id_ex_t`, a packed struct of the resolved bundle (pc4, a, b, rt_data, rs, rt, dest, shamt, alu_op, the five control bits);
  - opcode constants, including ANDI/ORI/XORI (`6'b001100`/`6'b001101`/`6'b001110`), shared with the extension unit.
- One sub-module, `skid_reg`, a generic 2-entry valid/ready buffer parameterised on the payload type.
- `id_ex_stage` does the resolution muxing and instantiates `skid_reg` with `id_ex_t`.

## Test plan
- Reset: assert `rst` 2 cycles with `in_valid` = 1 → `out_valid` = 0, all outputs 0, `in_ready` = 1 one cycle after release.
- Streaming:
  - ADDI `in_imm` = 32'hFFFF_FFFC, `alu_src` = 1, `rt` = 9, `reg_dst` = 0 → next cycle `out_b` = 32'hFFFF_FFFC, `out_dest` = 9.
  - Then R-type `rt_data` = 32'h0000_0007, `rd` = 12, `alu_src` = 0, `reg_dst` = 1 → `out_b` = 7, `out_dest` = 12 on the following cycle.
- Stall/skid: hold `out_ready` low while feeding 3 instructions:
  - `in_ready` drops after the second is accepted;
  - on release, outputs show instructions 1, 2, 3 in order, one per cycle;
  - the third is accepted once `in_ready` returns.
- Flush: with M and S both full, pulse `flush` together with `in_valid` = 1 → next cycle `out_valid` = 0 and `in_ready` = 1; the flushed and the same-cycle input never appear.
- Mid-stall reset: assert `rst` while S is full → next cycle both valids are 0, outputs are 0, and no pre-reset instruction emerges afterward.
- Random: constrained-random `in_valid`/`out_ready`/`flush` for 10k cycles against a reference queue model → order and content match exactly.
